// File: rtl/syst_ws_feeder.sv
// Input stage for the 3-lane weight-stationary array: buffers activation vectors,
// skews lane k by k cycles and flushes the skew with zeros at the end of each tile.
module syst_ws_feeder #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int FLUSH_CYC  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_x1_i,
   input  logic [DATA_W-1:0] s_x2_i,
   input  logic [DATA_W-1:0] s_x3_i,
   input  logic              s_last_i,
   output logic [DATA_W-1:0] x1_o,
   output logic [DATA_W-1:0] x2_o,
   output logic [DATA_W-1:0] x3_o,
   output logic [2:0]        lane_valid_o,
   output logic              done_o,
   output logic              busy_o,
   output logic [1:0]        dbg_state_o
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int FCNT_W = $clog2(FLUSH_CYC + 1);
   localparam int ENT_W  = 3 * DATA_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ENT_W-1:0]    r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [FCNT_W-1:0]   r_flush_cnt;
   logic                r_done;

   logic [DATA_W-1:0]   r_x1, r_a2, r_a3, r_x2, r_b3, r_x3;
   logic [2:0]          r_lv;

   logic                w_full, w_empty, w_push, w_pop;
   logic                w_flush_load, w_done_set;
   logic [ENT_W-1:0]    w_head;
   logic [DATA_W-1:0]   w_head_x1, w_head_x2, w_head_x3;
   logic                w_head_last;

   // Handshake: a vector transfers on a rising edge where s_valid_i & s_ready_o;
   // s_ready_o depends only on registered state, never on s_valid_i.
   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign s_ready_o = !w_full && (r_state != ST_FLUSH);
   assign w_push    = s_valid_i && s_ready_o;

   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_x1   = w_head[ENT_W-1 -: DATA_W];
   assign w_head_x2   = w_head[2*DATA_W -: DATA_W];
   assign w_head_x3   = w_head[DATA_W -: DATA_W];
   assign w_head_last = w_head[0];

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= {s_x1_i, s_x2_i, s_x3_i, s_last_i};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM: next state; a popped last vector goes straight to FLUSH even from IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) w_state_nxt = w_head_last ? ST_FLUSH : ST_STREAM;
         end
         ST_STREAM: begin
            if (!w_empty && w_head_last) w_state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (r_flush_cnt == FCNT_W'(1)) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_pop        = 1'b0;
      w_flush_load = 1'b0;
      w_done_set   = 1'b0;
      case (r_state)
         ST_IDLE, ST_STREAM: begin
            w_pop        = !w_empty;
            w_flush_load = !w_empty && w_head_last;
         end
         ST_FLUSH: begin
            w_done_set = (r_flush_cnt == FCNT_W'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_flush_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_done_set;
         if (w_flush_load)
            r_flush_cnt <= FCNT_W'(FLUSH_CYC);
         else if (r_state == ST_FLUSH)
            r_flush_cnt <= r_flush_cnt - FCNT_W'(1);
      end
   end

   // Skew pipeline shifts every cycle; a non-pop cycle injects zeros so no stale data leaks out.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_x1 <= '0;
         r_a2 <= '0;
         r_a3 <= '0;
         r_x2 <= '0;
         r_b3 <= '0;
         r_x3 <= '0;
         r_lv <= '0;
      end else begin
         r_x1 <= w_pop ? w_head_x1 : '0;
         r_a2 <= w_pop ? w_head_x2 : '0;
         r_a3 <= w_pop ? w_head_x3 : '0;
         r_x2 <= r_a2;
         r_b3 <= r_a3;
         r_x3 <= r_b3;
         r_lv <= {r_lv[1:0], w_pop};
      end
   end

   assign x1_o         = r_x1;
   assign x2_o         = r_x2;
   assign x3_o         = r_x3;
   assign lane_valid_o = r_lv;
   assign done_o       = r_done;
   assign busy_o       = (r_state != ST_IDLE) || !w_empty || (|r_lv);
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_syst_ws_feeder.sv
// Directed bench for syst_ws_feeder: reset, single vector, back-to-back tile,
// flush back-pressure with a scoreboard, underflow bubbles and reset mid-tile.
module tb_syst_ws_feeder;

   localparam int DATA_W = 8;
   localparam int HS_LIMIT = 20;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              s_valid_i;
   logic              s_ready_o;
   logic [DATA_W-1:0] s_x1_i, s_x2_i, s_x3_i;
   logic              s_last_i;
   logic [DATA_W-1:0] x1_o, x2_o, x3_o;
   logic [2:0]        lane_valid_o;
   logic              done_o;
   logic              busy_o;
   logic [1:0]        dbg_state_o;

   int n_checks;
   int n_fail;
   bit mon_on;
   bit rec_on;

   logic [3*DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0]   q1[$], q2[$], q3[$];

   syst_ws_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .FLUSH_CYC(2)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .s_valid_i    (s_valid_i),
      .s_ready_o    (s_ready_o),
      .s_x1_i       (s_x1_i),
      .s_x2_i       (s_x2_i),
      .s_x3_i       (s_x3_i),
      .s_last_i     (s_last_i),
      .x1_o         (x1_o),
      .x2_o         (x2_o),
      .x3_o         (x3_o),
      .lane_valid_o (lane_valid_o),
      .done_o       (done_o),
      .busy_o       (busy_o),
      .dbg_state_o  (dbg_state_o)
   );

   // clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic l);
      s_valid_i = 1'b1;
      s_x1_i    = a;
      s_x2_i    = b;
      s_x3_i    = c;
      s_last_i  = l;
   endtask

   task automatic idle_in();
      s_valid_i = 1'b0;
      s_x1_i    = '0;
      s_x2_i    = '0;
      s_x3_i    = '0;
      s_last_i  = 1'b0;
   endtask

   task automatic drive_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic l, output int waited);
      set_vec(a, b, c, l);
      waited = 0;
      while (!s_ready_o && waited < HS_LIMIT) begin
         step();
         waited++;
      end
      check_eq("hs_bound", 32'(waited < HS_LIMIT), 32'd1);
      step();
      idle_in();
   endtask

   // monitor: lanes must be zero when not valid; record valid lane data in order
   always @(negedge clk_i) begin
      if (mon_on) begin
         if (!lane_valid_o[0]) check_eq("lane1_zero", 32'(x1_o), 32'd0);
         if (!lane_valid_o[1]) check_eq("lane2_zero", 32'(x2_o), 32'd0);
         if (!lane_valid_o[2]) check_eq("lane3_zero", 32'(x3_o), 32'd0);
         if (rec_on) begin
            if (lane_valid_o[0]) q1.push_back(x1_o);
            if (lane_valid_o[1]) q2.push_back(x2_o);
            if (lane_valid_o[2]) q3.push_back(x3_o);
         end
      end
   end

   initial begin
      logic [7:0] e1, e2, e3;
      int w;
      int m;
      n_checks = 0;
      n_fail   = 0;
      mon_on   = 0;
      rec_on   = 0;
      idle_in();

      // reset asserted between edges
      rst_i = 1'b1;
      #2 rst_i = 1'b0;
      #1;
      check_eq("rst_x1", 32'(x1_o), 32'd0);
      check_eq("rst_x2", 32'(x2_o), 32'd0);
      check_eq("rst_x3", 32'(x3_o), 32'd0);
      check_eq("rst_lv", 32'(lane_valid_o), 32'd0);
      check_eq("rst_done", 32'(done_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      step();
      step();
      rst_i = 1'b1;
      check_eq("rst_ready", 32'(s_ready_o), 32'd1);
      mon_on = 1;

      // single vector with last
      set_vec(8'h11, 8'h22, 8'h33, 1'b1);
      step();
      idle_in();
      check_eq("t1_e1_lv", 32'(lane_valid_o), 32'd0);
      check_eq("t1_e1_busy", 32'(busy_o), 32'd1);
      step();
      check_eq("t1_e2_x1", 32'(x1_o), 32'h11);
      check_eq("t1_e2_lv", 32'(lane_valid_o), 32'd1);
      check_eq("t1_e2_ready", 32'(s_ready_o), 32'd0);
      check_eq("t1_e2_done", 32'(done_o), 32'd0);
      step();
      check_eq("t1_e3_x2", 32'(x2_o), 32'h22);
      check_eq("t1_e3_lv", 32'(lane_valid_o), 32'd2);
      check_eq("t1_e3_done", 32'(done_o), 32'd0);
      step();
      check_eq("t1_e4_x3", 32'(x3_o), 32'h33);
      check_eq("t1_e4_lv", 32'(lane_valid_o), 32'd4);
      check_eq("t1_e4_done", 32'(done_o), 32'd1);
      check_eq("t1_e4_ready", 32'(s_ready_o), 32'd1);
      step();
      check_eq("t1_e5_done", 32'(done_o), 32'd0);
      check_eq("t1_e5_busy", 32'(busy_o), 32'd0);

      // back-to-back tile of 4: vector i = {i, i+0x10, i+0x20}
      set_vec(8'h01, 8'h11, 8'h21, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         step();
         if (n < 4) set_vec(8'(n + 1), 8'(n + 1 + 16), 8'(n + 1 + 32), (n + 1) == 4);
         else       idle_in();
         e1 = (n >= 2 && n <= 5) ? 8'(n - 1)      : 8'h00;
         e2 = (n >= 3 && n <= 6) ? 8'(n - 2 + 16) : 8'h00;
         e3 = (n >= 4 && n <= 7) ? 8'(n - 3 + 32) : 8'h00;
         check_eq($sformatf("t2_e%0d_x1", n), 32'(x1_o), 32'(e1));
         check_eq($sformatf("t2_e%0d_x2", n), 32'(x2_o), 32'(e2));
         check_eq($sformatf("t2_e%0d_x3", n), 32'(x3_o), 32'(e3));
         check_eq($sformatf("t2_e%0d_lv", n), 32'(lane_valid_o), 32'({e3 != 0, e2 != 0, e1 != 0}));
         check_eq($sformatf("t2_e%0d_done", n), 32'(done_o), 32'(n == 7));
      end
      check_eq("t2_idle_busy", 32'(busy_o), 32'd0);

      // back-pressure during flush: two tiles of 4, vector 5 is held off for 2 cycles
      exp_q.delete();
      q1.delete();
      q2.delete();
      q3.delete();
      rec_on = 1;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k)});
         drive_vec(8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k), (k == 3 || k == 7), w);
         check_eq($sformatf("t3_wait_v%0d", k), 32'(w), (k == 5) ? 32'd2 : 32'd0);
      end
      repeat (8) step();
      rec_on = 0;
      check_eq("t3_n_lane1", 32'(q1.size()), 32'(exp_q.size()));
      check_eq("t3_n_lane2", 32'(q2.size()), 32'(exp_q.size()));
      check_eq("t3_n_lane3", 32'(q3.size()), 32'(exp_q.size()));
      m = exp_q.size();
      if (q1.size() < m) m = q1.size();
      if (q2.size() < m) m = q2.size();
      if (q3.size() < m) m = q3.size();
      for (int i = 0; i < m; i++)
         check_eq($sformatf("t3_order_%0d", i), 32'({q1[i], q2[i], q3[i]}), 32'(exp_q[i]));

      // underflow bubbles: A, two idle cycles, B(last)
      set_vec(8'h5A, 8'h6A, 8'h7A, 1'b0);
      step();
      idle_in();
      step();
      check_eq("t4_a1_x1", 32'(x1_o), 32'h5A);
      check_eq("t4_a1_v0", 32'(lane_valid_o[0]), 32'd1);
      step();
      check_eq("t4_a2_x1", 32'(x1_o), 32'd0);
      check_eq("t4_a2_v0", 32'(lane_valid_o[0]), 32'd0);
      check_eq("t4_a2_x2", 32'(x2_o), 32'h6A);
      check_eq("t4_a2_busy", 32'(busy_o), 32'd1);
      set_vec(8'hB5, 8'hC5, 8'hD5, 1'b1);
      step();
      idle_in();
      check_eq("t4_a3_x1", 32'(x1_o), 32'd0);
      check_eq("t4_a3_v0", 32'(lane_valid_o[0]), 32'd0);
      check_eq("t4_a3_x2", 32'(x2_o), 32'd0);
      step();
      check_eq("t4_a4_x1", 32'(x1_o), 32'hB5);
      check_eq("t4_a4_v0", 32'(lane_valid_o[0]), 32'd1);
      step();
      check_eq("t4_a5_x2", 32'(x2_o), 32'hC5);
      check_eq("t4_a5_done", 32'(done_o), 32'd0);
      step();
      check_eq("t4_a6_x3", 32'(x3_o), 32'hD5);
      check_eq("t4_a6_done", 32'(done_o), 32'd1);
      step();
      check_eq("t4_a7_busy", 32'(busy_o), 32'd0);

      // reset in the middle of a tile
      set_vec(8'h31, 8'h41, 8'h51, 1'b0);
      step();
      set_vec(8'h32, 8'h42, 8'h52, 1'b0);
      step();
      set_vec(8'h33, 8'h43, 8'h53, 1'b0);
      step();
      idle_in();
      check_eq("t5_pre_lv", 32'(lane_valid_o), 32'd3);
      check_eq("t5_pre_busy", 32'(busy_o), 32'd1);
      #1 rst_i = 1'b0;
      #1;
      check_eq("t5_rst_x1", 32'(x1_o), 32'd0);
      check_eq("t5_rst_x2", 32'(x2_o), 32'd0);
      check_eq("t5_rst_x3", 32'(x3_o), 32'd0);
      check_eq("t5_rst_lv", 32'(lane_valid_o), 32'd0);
      check_eq("t5_rst_busy", 32'(busy_o), 32'd0);
      for (int n = 0; n < 2; n++) begin
         step();
         check_eq("t5_hold_done", 32'(done_o), 32'd0);
         check_eq("t5_hold_lv", 32'(lane_valid_o), 32'd0);
      end
      rst_i = 1'b1;
      check_eq("t5_rel_ready", 32'(s_ready_o), 32'd1);
      check_eq("t5_rel_busy", 32'(busy_o), 32'd0);
      step();
      check_eq("t5_nostale_lv", 32'(lane_valid_o), 32'd0);
      check_eq("t5_nostale_done", 32'(done_o), 32'd0);
      check_eq("t5_nostale_busy", 32'(busy_o), 32'd0);
      set_vec(8'hA1, 8'hA2, 8'hA3, 1'b1);
      step();
      idle_in();
      step();
      check_eq("t5_new_x1", 32'(x1_o), 32'hA1);
      step();
      check_eq("t5_new_x2", 32'(x2_o), 32'hA2);
      step();
      check_eq("t5_new_x3", 32'(x3_o), 32'hA3);
      check_eq("t5_new_done", 32'(done_o), 32'd1);
      step();
      check_eq("t5_end_done", 32'(done_o), 32'd0);
      check_eq("t5_end_busy", 32'(busy_o), 32'd0);

      mon_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
